riscv_icache_refill: RTL and testbench

Memory-side responder for the instruction-cache reload interface. It accepts a line reload request from the I-cache and fetches the 32-byte line from a 32-bit word memory into a local line buffer. It then answers with five back-to-back `reload_ack` beats, with `reload_data` delayed by two acks, which is the order the cache's reload counter expects. It sits between `riscv_icache` and the instruction memory/bus port.

---
 rtl/riscv_icache_pkg.sv | 17 +
 rtl/riscv_icache_refill.sv | 155 +++++++++++++++
 tb/tb_riscv_icache_refill.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_icache_pkg.sv
// Shared definitions for the I-cache reload responder: FSM encoding and line geometry.
package riscv_icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ABORT  = 2'd2,
    ST_STREAM = 2'd3
  } state_t;

  localparam int LINE_WORDS     = 8;
  localparam int RELOAD_BEATS   = 5;
  localparam int ACK_DATA_DELAY = 2;
  localparam int LINE_OFFSET_W  = 5;
  localparam int LINE_ADDR_W    = 32 - LINE_OFFSET_W;

endpackage

// File: rtl/riscv_icache_refill.sv
// Fetches a 32-byte line word by word into a local buffer, then answers the
// I-cache with five consecutive reload acks, data lagging the acks by two.
module riscv_icache_refill
  import riscv_icache_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    reload_req,
  input  logic [31:0]             reload_addr,
  output logic                    reload_ack,
  output logic [2*DATA_WIDTH-1:0] reload_data,
  input  logic                    inv,
  output logic                    mem_req,
  output logic [31:0]             mem_addr,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  state_t                   state_reg, state_next;
  logic [LINE_ADDR_W-1:0]   line_addr_reg;
  logic                     buf_valid_reg;
  logic                     fetch_inv_reg;
  logic [2:0]               w_reg;
  logic [2:0]               c_reg;
  logic [DATA_WIDTH-1:0]    line_buf [LINE_WORDS];

  logic [LINE_ADDR_W-1:0]   req_line;
  logic                     hit;
  logic                     last_word;
  logic [1:0]               beat_k;
  logic                     unused_offset;

  assign req_line      = reload_addr[31:LINE_OFFSET_W];
  assign unused_offset = ^reload_addr[LINE_OFFSET_W-1:0];
  // A same-cycle inv must not let a request hit the line it is invalidating.
  assign hit           = buf_valid_reg && !inv && (req_line == line_addr_reg);
  assign last_word     = (w_reg == 3'(LINE_WORDS - 1));
  // c=2..5 maps to beats 0..3; the 2-bit wrap does the subtraction for free.
  assign beat_k        = c_reg[1:0] - 2'(ACK_DATA_DELAY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (reload_req) begin
          state_next = hit ? ST_STREAM : ST_FETCH;
        end
      end
      ST_FETCH: begin
        // A read completing in the same cycle as the drop needs no abort wait.
        if (!reload_req) begin
          state_next = mem_rvalid ? ST_IDLE : ST_ABORT;
        end else if (mem_rvalid && last_word) begin
          state_next = ST_STREAM;
        end
      end
      ST_ABORT: begin
        if (mem_rvalid) begin
          state_next = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (!reload_req) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    reload_ack  = 1'b0;
    reload_data = '0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    case (state_reg)
      ST_FETCH, ST_ABORT: begin
        mem_req  = 1'b1;
        mem_addr = {line_addr_reg, w_reg, 2'b00};
      end
      ST_STREAM: begin
        reload_ack = reload_req && (c_reg < 3'(RELOAD_BEATS));
        if (c_reg >= 3'(ACK_DATA_DELAY) && c_reg <= 3'(RELOAD_BEATS)) begin
          reload_data = {line_buf[{beat_k, 1'b1}], line_buf[{beat_k, 1'b0}]};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_addr_reg <= '0;
      buf_valid_reg <= 1'b0;
      fetch_inv_reg <= 1'b0;
      w_reg         <= '0;
      c_reg         <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (reload_req) begin
            line_addr_reg <= req_line;
            c_reg         <= '0;
            if (!hit) begin
              w_reg         <= '0;
              buf_valid_reg <= 1'b0;
              fetch_inv_reg <= 1'b0;
            end
          end
        end
        ST_FETCH: begin
          if (mem_rvalid) begin
            w_reg <= w_reg + 3'd1;
            if (last_word && reload_req) begin
              buf_valid_reg <= !(fetch_inv_reg || inv);
              c_reg         <= '0;
            end
          end
          if (inv) begin
            fetch_inv_reg <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (!reload_req) begin
            c_reg <= '0;
          end else if (reload_ack) begin
            c_reg <= c_reg + 3'd1;
          end
        end
        default: ;
      endcase
      if (inv) begin
        buf_valid_reg <= 1'b0;
      end
    end
  end

  // Buffer is plain storage; words returned during ABORT are dropped here.
  always_ff @(posedge clk) begin
    if (state_reg == ST_FETCH && mem_rvalid) begin
      line_buf[w_reg] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_riscv_icache_refill.sv
// Directed bench for riscv_icache_refill: miss, hit, wait states, flushes, inv and reset.
module tb_riscv_icache_refill;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          reload_req;
  logic [31:0]   reload_addr;
  logic          reload_ack;
  logic [63:0]   reload_data;
  logic          inv;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic          mem_rvalid;
  logic [DW-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_icache_refill #(.DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .reload_req  (reload_req),
    .reload_addr (reload_addr),
    .reload_ack  (reload_ack),
    .reload_data (reload_data),
    .inv         (inv),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [31:0] base, input int k);
    logic [31:0] lo;
    lo = base + 32'(8 * k);
    return {lo + 32'd4, lo};
  endfunction

  // One cycle: drive inputs just after the falling edge, then let comb outputs settle.
  task automatic tick(input logic req, input logic rv, input logic [31:0] rd, input logic iv);
    @(negedge clk);
    reload_req = req;
    mem_rvalid = rv;
    mem_rdata  = rd;
    inv        = iv;
    #1;
  endtask

  task automatic issue(input logic [31:0] addr);
    reload_addr = addr;
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("req_cycle_mem_req", 64'(mem_req), 64'd0);
    chk("req_cycle_ack", 64'(reload_ack), 64'd0);
  endtask

  task automatic fetch_words(input logic [31:0] base, input int first, input int last,
                             input bit gaps, input int inv_at);
    for (int i = first; i <= last; i++) begin
      if (gaps) begin
        int n = int'($urandom_range(0, 5));
        for (int g = 0; g < n; g++) begin
          tick(1'b1, 1'b0, 32'h0, 1'b0);
          chk("wait_mem_req", 64'(mem_req), 64'd1);
          chk("wait_mem_addr", 64'(mem_addr), 64'(base + 32'(4 * i)));
          chk("wait_ack", 64'(reload_ack), 64'd0);
        end
      end
      tick(1'b1, 1'b1, base + 32'(4 * i), (i == inv_at));
      chk("fetch_mem_req", 64'(mem_req), 64'd1);
      chk("fetch_mem_addr", 64'(mem_addr), 64'(base + 32'(4 * i)));
      chk("fetch_ack", 64'(reload_ack), 64'd0);
    end
  endtask

  task automatic stream(input logic [31:0] base, input int hold);
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      chk("stream_ack", 64'(reload_ack), 64'd1);
      chk("stream_data", reload_data, (c < 2) ? 64'd0 : beat(base, c - 2));
      chk("stream_mem_req", 64'(mem_req), 64'd0);
    end
    for (int h = 0; h < hold; h++) begin
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      chk("hold_ack", 64'(reload_ack), 64'd0);
      chk("hold_data", reload_data, beat(base, 3));
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    chk("drop_ack", 64'(reload_ack), 64'd0);
    chk("drop_data", reload_data, beat(base, 3));
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    chk("idle_ack", 64'(reload_ack), 64'd0);
    chk("idle_data", reload_data, 64'd0);
    chk("idle_mem_req", 64'(mem_req), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    reload_req = 1'b0;
    reload_addr = 32'h0;
    inv = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = '0;
    #1;
    chk("reset_ack", 64'(reload_ack), 64'd0);
    chk("reset_data", reload_data, 64'd0);
    chk("reset_mem_req", 64'(mem_req), 64'd0);
    chk("reset_mem_addr", 64'(mem_addr), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Cold miss, rvalid every cycle, request held two cycles past the last ack
    issue(32'h0000_1040);
    fetch_words(32'h0000_1040, 0, 7, 1'b0, -1);
    stream(32'h0000_1040, 2);

    // Same line with a different offset: hit, no memory traffic
    issue(32'h0000_1058);
    stream(32'h0000_1040, 0);

    // inv while idle forces a refetch; memory wait states only stretch FETCH
    tick(1'b0, 1'b0, 32'h0, 1'b1);
    issue(32'h0000_1040);
    fetch_words(32'h0000_1040, 0, 7, 1'b1, -1);
    stream(32'h0000_1040, 0);

    // Flush in FETCH after word 3 with word 4 outstanding
    issue(32'h0000_3000);
    fetch_words(32'h0000_3000, 0, 3, 1'b0, -1);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    chk("abort_mem_req", 64'(mem_req), 64'd1);
    chk("abort_mem_addr", 64'(mem_addr), 64'h3010);
    chk("abort_ack", 64'(reload_ack), 64'd0);
    tick(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    chk("abort_rvalid_mem_req", 64'(mem_req), 64'd1);
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    chk("abort_done_mem_req", 64'(mem_req), 64'd0);
    chk("abort_done_ack", 64'(reload_ack), 64'd0);
    issue(32'h0000_3000);
    fetch_words(32'h0000_3000, 0, 7, 1'b0, -1);
    stream(32'h0000_3000, 0);

    // Flush in STREAM at c=2, then the same line is still a hit with c restarted
    issue(32'h0000_3000);
    for (int c = 0; c < 2; c++) begin
      tick(1'b1, 1'b0, 32'h0, 1'b0);
      chk("flush_stream_ack", 64'(reload_ack), 64'd1);
    end
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    chk("flush_c2_ack", 64'(reload_ack), 64'd0);
    chk("flush_c2_data", reload_data, beat(32'h0000_3000, 0));
    tick(1'b0, 1'b0, 32'h0, 1'b0);
    chk("flush_idle_data", reload_data, 64'd0);
    issue(32'h0000_3000);
    stream(32'h0000_3000, 0);

    // inv during FETCH: stream completes from buffer, but the line is not kept
    issue(32'h0000_4000);
    fetch_words(32'h0000_4000, 0, 7, 1'b0, 2);
    stream(32'h0000_4000, 0);
    issue(32'h0000_4000);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("inv_fetch_refetch", 64'(mem_req), 64'd1);
    // inv on the final word beats the valid set
    fetch_words(32'h0000_4000, 0, 7, 1'b0, 7);
    stream(32'h0000_4000, 0);
    issue(32'h0000_4000);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("inv_last_refetch", 64'(mem_req), 64'd1);
    chk("inv_last_addr", 64'(mem_addr), 64'h4000);

    // Reset mid-FETCH clears outputs asynchronously and returns to IDLE
    fetch_words(32'h0000_4000, 0, 2, 1'b0, -1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_mem_req", 64'(mem_req), 64'd0);
    chk("async_rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("async_rst_ack", 64'(reload_ack), 64'd0);
    chk("async_rst_data", reload_data, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    reload_req = 1'b0;
    #1;
    chk("post_rst_mem_req", 64'(mem_req), 64'd0);
    issue(32'h0000_4000);
    tick(1'b1, 1'b0, 32'h0, 1'b0);
    chk("post_rst_fetch", 64'(mem_req), 64'd1);
    chk("post_rst_addr", 64'(mem_addr), 64'h4000);
    fetch_words(32'h0000_4000, 0, 7, 1'b0, -1);
    stream(32'h0000_4000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
